exe_stage_mc: RTL

EXE_STAGE_MC -- requirements
Module: exe_stage_mc

---
 rtl/exe_stage_mc_pkg.sv | 25 ++
 rtl/exe_stage_mc_divu.sv | 68 ++++++
 rtl/exe_stage_mc.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/exe_stage_mc_pkg.sv
// Shared types for the execute stage: operation codes and the control FSM state.
package exe_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_LUI  = 4'd10,
    OP_DIVU = 4'd11,
    OP_REMU = 4'd12
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } state_e;

endpackage

// File: rtl/exe_stage_mc_divu.sv
// Iterative restoring unsigned divider, one quotient bit per cycle (XLEN cycles).
// Present only when EXE_STAGE_DIV_EN is defined.
`ifdef EXE_STAGE_DIV_EN
module exe_divu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN + 1);

  logic            run_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   rem_sub;

  // A zero divisor never borrows, so the quotient fills with ones and the
  // remainder accumulates the dividend without any special casing.
  always_comb begin
    rem_sh  = {rem_q, quo_q[XLEN-1]};
    rem_sub = rem_sh - {1'b0, dvs_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (abort) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      cnt_q <= CW'(XLEN);
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (run_q && cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
      if (!rem_sub[XLEN]) begin
        rem_q <= rem_sub[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= rem_sh[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  assign done      = run_q && (cnt_q == '0);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule
`endif

// File: rtl/exe_stage_mc.sv
// Execute stage: single-cycle ALU into a one-entry EXE/MEM output register.
// Define EXE_STAGE_DIV_EN to add the multi-cycle DIVU/REMU path.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | accepting; single-cycle ops load the output register directly
//   ST_DIV  | divider running, or result waiting for the output register
module exe_stage_mc
  import exe_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h1c000000)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [XLEN-1:0] in_mem_wdata,
  input  logic [3:0]      in_op,
  input  logic            in_rf_we,
  input  logic [4:0]      in_rf_waddr,
  input  logic            in_mem_we,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_mem_wdata,
  output logic            out_rf_we,
  output logic [4:0]      out_rf_waddr,
  output logic            out_mem_we,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] mem_wdata_q;
  logic            rf_we_q;
  logic [4:0]      rf_waddr_q;
  logic            mem_we_q;

  logic            out_free;
  logic            accept;
  logic            is_div_op;
  logic            ld_div;
  logic            load;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] ld_pc;
  logic [XLEN-1:0] ld_result;
  logic [XLEN-1:0] ld_mem_wdata;
  logic            ld_rf_we;
  logic [4:0]      ld_rf_waddr;
  logic            ld_mem_we;

  assign shamt = in_src2[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (in_op)
      OP_ADD:  alu_res = in_src1 + in_src2;
      OP_SUB:  alu_res = in_src1 - in_src2;
      OP_AND:  alu_res = in_src1 & in_src2;
      OP_OR:   alu_res = in_src1 | in_src2;
      OP_XOR:  alu_res = in_src1 ^ in_src2;
      OP_SLL:  alu_res = in_src1 << shamt;
      OP_SRL:  alu_res = in_src1 >> shamt;
      OP_SRA:  alu_res = $signed(in_src1) >>> shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(in_src1) < $signed(in_src2))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (in_src1 < in_src2)};
      OP_LUI:  alu_res = in_src2;
      default: alu_res = '0;
    endcase
  end

  assign out_free = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

`ifdef EXE_STAGE_DIV_EN
  state_e          state_q;
  logic            is_rem_q;
  logic [XLEN-1:0] pend_pc_q;
  logic [XLEN-1:0] pend_wdata_q;
  logic            pend_rf_we_q;
  logic [4:0]      pend_waddr_q;
  logic            pend_mem_we_q;
  logic            div_done;
  logic [XLEN-1:0] div_quo;
  logic [XLEN-1:0] div_rem;

  assign is_div_op = (in_op == OP_DIVU) || (in_op == OP_REMU);
  assign in_ready  = (state_q == ST_IDLE) && out_free;
  // A finished division waits here until the output register can take it.
  assign ld_div    = (state_q == ST_DIV) && div_done && out_free;
  assign busy      = (state_q == ST_DIV);

  exe_divu #(.XLEN(XLEN)) u_divu (
    .clk       (clk),
    .reset     (reset),
    .start     (accept && is_div_op),
    .abort     (flush || ld_div),
    .dividend  (in_src1),
    .divisor   (in_src2),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );
`else
  assign is_div_op = 1'b0;
  assign in_ready  = out_free;
  assign ld_div    = 1'b0;
  assign busy      = 1'b0;
`endif

  assign load = (accept && !is_div_op) || ld_div;

  always_comb begin
    ld_pc        = in_pc;
    ld_result    = alu_res;
    ld_mem_wdata = in_mem_wdata;
    ld_rf_we     = in_rf_we;
    ld_rf_waddr  = in_rf_waddr;
    ld_mem_we    = in_mem_we;
`ifdef EXE_STAGE_DIV_EN
    if (state_q == ST_DIV) begin
      ld_pc        = pend_pc_q;
      ld_result    = is_rem_q ? div_rem : div_quo;
      ld_mem_wdata = pend_wdata_q;
      ld_rf_we     = pend_rf_we_q;
      ld_rf_waddr  = pend_waddr_q;
      ld_mem_we    = pend_mem_we_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      pc_q        <= RESET_PC;
      result_q    <= '0;
      mem_wdata_q <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      mem_we_q    <= 1'b0;
`ifdef EXE_STAGE_DIV_EN
      state_q       <= ST_IDLE;
      is_rem_q      <= 1'b0;
      pend_pc_q     <= '0;
      pend_wdata_q  <= '0;
      pend_rf_we_q  <= 1'b0;
      pend_waddr_q  <= '0;
      pend_mem_we_q <= 1'b0;
`endif
    end else if (flush) begin
      valid_q  <= 1'b0;
      rf_we_q  <= 1'b0;
      mem_we_q <= 1'b0;
`ifdef EXE_STAGE_DIV_EN
      state_q  <= ST_IDLE;
`endif
    end else begin
      if (load) begin
        valid_q     <= 1'b1;
        pc_q        <= ld_pc;
        result_q    <= ld_result;
        mem_wdata_q <= ld_mem_wdata;
        rf_we_q     <= ld_rf_we;
        rf_waddr_q  <= ld_rf_waddr;
        mem_we_q    <= ld_mem_we;
      end else if (valid_q && out_ready) begin
        valid_q  <= 1'b0;
        rf_we_q  <= 1'b0;
        mem_we_q <= 1'b0;
      end
`ifdef EXE_STAGE_DIV_EN
      if (accept && is_div_op) begin
        state_q       <= ST_DIV;
        is_rem_q      <= (in_op == OP_REMU);
        pend_pc_q     <= in_pc;
        pend_wdata_q  <= in_mem_wdata;
        pend_rf_we_q  <= in_rf_we;
        pend_waddr_q  <= in_rf_waddr;
        pend_mem_we_q <= in_mem_we;
      end else if (ld_div) begin
        state_q <= ST_IDLE;
      end
`endif
    end
  end

  assign out_valid     = valid_q;
  assign out_pc        = pc_q;
  assign out_result    = result_q;
  assign out_mem_wdata = mem_wdata_q;
  assign out_rf_we     = rf_we_q;
  assign out_rf_waddr  = rf_waddr_q;
  assign out_mem_we    = mem_we_q;

endmodule
